// File: rtl/xor_absorb_unit.sv
// Rate-absorb stage of a sponge construction: XORs (or overwrites, for decrypt) input
// blocks into the rate of a 5x64-bit state and hands the state back for permutation.
module xor_absorb_unit #(
    parameter int RATE_WORDS = 2,
    parameter int CNT_W      = 16
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic [4:0][63:0]                     state_i,
    input  logic                                 load_state_i,
    input  logic [1:0]                           mode_i,
    input  logic [64*RATE_WORDS-1:0]             data_i,
    input  logic [$clog2(8*RATE_WORDS+1)-1:0]    data_bytes_i,
    input  logic                                 last_i,
    input  logic                                 data_valid_i,
    output logic                                 data_ready_o,
    output logic [4:0][63:0]                     state_o,
    output logic [64*RATE_WORDS-1:0]             data_o,
    output logic                                 out_valid_o,
    output logic                                 perm_req_o,
    output logic                                 phase_done_o,
    output logic [CNT_W-1:0]                     blk_cnt_o
);

    localparam int RB    = 8 * RATE_WORDS;
    localparam int RBITS = 64 * RATE_WORDS;

    typedef enum logic [2:0] {S_IDLE, S_READY, S_OUT, S_WAIT, S_PAD} fsm_t;

    fsm_t              state_q, state_d;
    logic              last_q, pad_q;
    logic              xfer;
    int                n_eff;
    logic [RBITS-1:0]  rate_old, rate_new, out_new;

    assign xfer     = (state_q == S_READY) && data_valid_i;
    assign rate_old = state_o[RATE_WORDS-1:0];

    // Out-of-range byte counts mean a full block.
    always_comb begin
        n_eff = int'(data_bytes_i);
        if (n_eff == 0 || n_eff > RB) n_eff = RB;
    end

    always_comb begin
        rate_new = rate_old;
        out_new  = '0;
        for (int i = 0; i < RB; i++) begin
            if (i < n_eff) begin
                out_new[8*i +: 8] = rate_old[8*i +: 8] ^ data_i[8*i +: 8];
                if (mode_i == 2'b10) rate_new[8*i +: 8] = data_i[8*i +: 8];
                else                 rate_new[8*i +: 8] = out_new[8*i +: 8];
            end else if (i == n_eff) begin
                rate_new[8*i +: 8] = rate_old[8*i +: 8] ^ 8'h01;
            end
        end
        // Encrypt output equals the new rate and decrypt output is old^data; both are old^data.
        if (!(mode_i == 2'b01 || mode_i == 2'b10)) out_new = '0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load_state_i) state_d = S_READY;
            S_READY: if (data_valid_i) state_d = S_OUT;
            S_OUT:   state_d = S_WAIT;
            S_WAIT:  if (load_state_i) state_d = pad_q ? S_PAD : S_READY;
            S_PAD:   state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_ready_o = (state_q == S_READY);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_o      <= '0;
            data_o       <= '0;
            out_valid_o  <= 1'b0;
            perm_req_o   <= 1'b0;
            phase_done_o <= 1'b0;
            blk_cnt_o    <= '0;
            last_q       <= 1'b0;
            pad_q        <= 1'b0;
        end else begin
            out_valid_o  <= 1'b0;
            phase_done_o <= 1'b0;
            case (state_q)
                S_IDLE: if (load_state_i) state_o <= state_i;
                S_READY: if (xfer) begin
                    state_o[RATE_WORDS-1:0] <= rate_new;
                    data_o      <= out_new;
                    out_valid_o <= (mode_i == 2'b01) || (mode_i == 2'b10);
                    blk_cnt_o   <= blk_cnt_o + CNT_W'(1);
                    last_q      <= last_i;
                    pad_q       <= last_i && (n_eff == RB);
                end
                S_OUT: perm_req_o <= 1'b1;
                S_WAIT: if (load_state_i) begin
                    state_o    <= state_i;
                    perm_req_o <= 1'b0;
                    if (!pad_q && last_q) phase_done_o <= 1'b1;
                    if (!pad_q) last_q <= 1'b0;
                end
                S_PAD: begin
                    // A full final block leaves no room for padding, so it gets its own block.
                    state_o[0][7:0] <= state_o[0][7:0] ^ 8'h01;
                    blk_cnt_o       <= blk_cnt_o + CNT_W'(1);
                    phase_done_o    <= 1'b1;
                    perm_req_o      <= 1'b1;
                    pad_q           <= 1'b0;
                    last_q          <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_absorb_unit.sv
// Scoreboard bench for xor_absorb_unit: a byte-level sponge model predicts every output
// pulse, and a negedge monitor compares the DUT against the queued predictions.
module tb_xor_absorb_unit;
    localparam int RW = 2;
    localparam int CW = 4;

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic [4:0][63:0]  state_i, state_o;
    logic              load_state_i;
    logic [1:0]        mode_i;
    logic [127:0]      data_i, data_o;
    logic [4:0]        data_bytes_i;
    logic              last_i, data_valid_i, data_ready_o;
    logic              out_valid_o, perm_req_o, phase_done_o;
    logic [CW-1:0]     blk_cnt_o;

    xor_absorb_unit #(.RATE_WORDS(RW), .CNT_W(CW)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .state_i(state_i), .load_state_i(load_state_i),
        .mode_i(mode_i), .data_i(data_i), .data_bytes_i(data_bytes_i), .last_i(last_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .state_o(state_o),
        .data_o(data_o), .out_valid_o(out_valid_o), .perm_req_o(perm_req_o),
        .phase_done_o(phase_done_o), .blk_cnt_o(blk_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [CW-1:0]    cnt;
        logic [4:0][63:0] st;
    } done_t;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [4:0][63:0] m_st;
    logic [CW-1:0]    m_cnt;
    bit               m_pad, m_last;
    logic [127:0]     exp_out_q[$];
    done_t            exp_done_q[$];

    localparam logic [127:0] PLAIN  = 128'h0000626F42206F74206563696C41;
    localparam logic [127:0] CIPHER = 128'h00000000F67C2DAA_EDCBB14C28CCECCC;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0][63:0] rand_state();
        logic [4:0][63:0] s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    function automatic logic [127:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every output pulse must match the oldest queued prediction.
    always @(negedge clock_i) begin
        if (!reset_i) begin
            if (out_valid_o) begin
                if (exp_out_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected out_valid_o: data_o %h, none expected", data_o);
                end else begin
                    check("data_o", 320'(data_o), 320'(exp_out_q.pop_front()));
                end
            end
            if (phase_done_o) begin
                if (exp_done_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected phase_done_o: blk_cnt %0d, none expected", blk_cnt_o);
                end else begin
                    done_t e;
                    e = exp_done_q.pop_front();
                    check("phase_done blk_cnt", 320'(blk_cnt_o), 320'(e.cnt));
                    check("phase_done state", state_o, e.st);
                end
            end
        end
    end

    task automatic wait_neg(input bit perm, input string name);
        int k = 0;
        @(negedge clock_i);
        while (((perm ? perm_req_o : data_ready_o) !== 1'b1) && k < 64) begin
            @(negedge clock_i);
            k++;
        end
        if (k >= 64) begin
            n_checks++; n_fail++;
            $display("FAIL timeout waiting for %s: signal %b required 1", name, perm ? perm_req_o : data_ready_o);
        end
    endtask

    task automatic load_st(input logic [4:0][63:0] s);
        state_i = s;
        load_state_i = 1'b1;
        @(negedge clock_i);
        load_state_i = 1'b0;
        m_st = s;
        if (m_pad) begin
            m_st[0][7:0] = m_st[0][7:0] ^ 8'h01;
            m_cnt++;
            exp_done_q.push_back(done_t'{cnt: m_cnt, st: m_st});
            m_pad = 0;
            m_last = 0;
        end else if (m_last) begin
            exp_done_q.push_back(done_t'{cnt: m_cnt, st: m_st});
            m_last = 0;
        end
    endtask

    // Model: byte-wise sponge absorb over the 16-byte rate, little-endian bytes.
    task automatic send(input logic [1:0] md, input logic [127:0] d, input logic [4:0] nb,
                        input bit lst, input bit hold);
        int n;
        logic [127:0] r, o, newrate;
        wait_neg(0, "data_ready_o");
        mode_i = md; data_i = d; data_bytes_i = nb; last_i = lst; data_valid_i = 1'b1;
        n = (nb == 0 || nb > 16) ? 16 : int'(nb);
        r = m_st[1:0];
        o = '0;
        newrate = r;
        for (int i = 0; i < n; i++) begin
            o[8*i +: 8] = r[8*i +: 8] ^ d[8*i +: 8];
            newrate[8*i +: 8] = (md == 2'b10) ? d[8*i +: 8] : o[8*i +: 8];
        end
        if (n < 16) newrate[8*n +: 8] = newrate[8*n +: 8] ^ 8'h01;
        if (md == 2'b01) begin
            logic [127:0] masked = '0;
            for (int i = 0; i < n; i++) masked[8*i +: 8] = newrate[8*i +: 8];
            exp_out_q.push_back(masked);
        end else if (md == 2'b10) begin
            exp_out_q.push_back(o);
        end
        m_st[1:0] = newrate;
        m_cnt++;
        m_last = lst;
        m_pad = lst && (n == 16);
        @(negedge clock_i);
        if (!hold) data_valid_i = 1'b0;
        check("state_o after transfer", state_o, m_st);
        check("blk_cnt_o after transfer", 320'(blk_cnt_o), 320'(m_cnt));
    endtask

    task automatic finish_block();
        bit p = m_pad;
        wait_neg(1, "perm_req_o");
        load_st(rand_state());
        if (p) begin
            wait_neg(1, "perm_req_o after pad");
            load_st(rand_state());
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
        m_st = '0; m_cnt = '0; m_pad = 0; m_last = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0][63:0] s0;
        reset_i = 1'b1; load_state_i = 1'b0; state_i = '0; mode_i = '0; data_i = '0;
        data_bytes_i = '0; last_i = 1'b0; data_valid_i = 1'b0;
        do_reset();
        check("reset state_o", state_o, '0);
        check("reset data_o", 320'(data_o), '0);
        check("reset flags", 320'({out_valid_o, perm_req_o, phase_done_o, data_ready_o}), '0);
        check("reset blk_cnt_o", 320'(blk_cnt_o), '0);

        // Full final block in AD mode forces a separate pad block.
        load_st(rand_state());
        send(2'b00, rand_data(), 5'd16, 1'b1, 1'b0);
        finish_block();
        check("scen2 blk_cnt_o", 320'(blk_cnt_o), 320'(2));

        // Known-answer encrypt then decrypt on the same start state.
        do_reset();
        s0 = rand_state();
        s0[0] = 64'h82bf91294ba5808d;
        s0[1] = 64'hd81eeca694136f8a;
        load_st(s0);
        send(2'b01, PLAIN, 5'd12, 1'b1, 1'b0);
        check("scen1 word0", 320'(state_o[0]), 320'(64'hEDCBB14C28CCECCC));
        check("scen1 word1", 320'(state_o[1]), 320'(64'hd81eeca7F67C2DAA));
        check("scen1 data_o", 320'(data_o), 320'(CIPHER));
        wait_neg(1, "perm_req_o");
        load_st(s0);
        send(2'b10, CIPHER, 5'd12, 1'b1, 1'b0);
        check("scen3 data_o", 320'(data_o), 320'(PLAIN));
        check("scen3 rate", 320'(state_o[1:0]), 320'({64'hd81eeca7F67C2DAA, 64'hEDCBB14C28CCECCC}));
        finish_block();

        // Held data_valid during OUT/WAIT, and a stray load in READY.
        send(2'b01, rand_data(), 5'd8, 1'b0, 1'b1);
        wait_neg(1, "perm_req_o");
        repeat (3) @(negedge clock_i);
        check("scen4 held state", state_o, m_st);
        check("scen4 held blk_cnt", 320'(blk_cnt_o), 320'(m_cnt));
        data_valid_i = 1'b0;
        load_st(rand_state());
        state_i = rand_state();
        load_state_i = 1'b1;
        @(negedge clock_i);
        load_state_i = 1'b0;
        check("scen4 load in READY", state_o, m_st);

        // Asynchronous reset while waiting for the permutation.
        send(2'b01, rand_data(), 5'd5, 1'b0, 1'b0);
        wait_neg(1, "perm_req_o");
        #2 reset_i = 1'b1;
        #1;
        check("scen5 async state_o", state_o, '0);
        check("scen5 async data_o", 320'(data_o), '0);
        check("scen5 async blk_cnt", 320'(blk_cnt_o), '0);
        check("scen5 async flags", 320'({out_valid_o, perm_req_o, phase_done_o, data_ready_o}), '0);
        @(negedge clock_i);
        reset_i = 1'b0;
        m_st = '0; m_cnt = '0; m_pad = 0; m_last = 0;
        mode_i = 2'b01; data_i = rand_data(); data_bytes_i = 5'd16; data_valid_i = 1'b1;
        repeat (5) @(negedge clock_i);
        data_valid_i = 1'b0;
        check("scen5 idle blk_cnt", 320'(blk_cnt_o), '0);
        check("scen5 idle state", state_o, '0);
        check("scen5 idle ready", 320'(data_ready_o), '0);

        // Random traffic; the 4-bit counter wraps several times.
        load_st(rand_state());
        for (int k = 0; k < 40; k++) begin
            send(2'($urandom_range(0, 3)), rand_data(), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'b0);
            finish_block();
        end

        do_reset();
        load_st(rand_state());
        for (int k = 0; k < 15; k++) begin
            send(2'b00, rand_data(), 5'd8, 1'b0, 1'b0);
            finish_block();
        end
        check("counter at 15", 320'(blk_cnt_o), 320'(15));
        send(2'b01, rand_data(), 5'd8, 1'b0, 1'b0);
        check("counter wrap 15->0", 320'(blk_cnt_o), '0);
        finish_block();

        repeat (4) @(negedge clock_i);
        check("out queue drained", 320'(exp_out_q.size()), '0);
        check("done queue drained", 320'(exp_done_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
